// File: rtl/instr_fetch_unit.sv
// Instruction fetch sequencer: reads 3 consecutive RAM bytes, assembles a 24-bit word, hands it off via valid/ready.
// Optional halt-on-all-ones-opcode behaviour is enabled by defining FETCH_HALT_DETECT_EN.
module instr_fetch_unit #(
  parameter int unsigned       ADDR_W   = 8,
  parameter int unsigned       DATA_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                fetch_en,
  output logic                mem_rd_en,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_data,
  input  logic                redirect,
  input  logic [ADDR_W-1:0]   redirect_addr,
  output logic                instr_valid,
  input  logic                instr_ready,
  output logic [3*DATA_W-1:0] instr,
  output logic [ADDR_W-1:0]   instr_pc,
  output logic                busy,
  output logic                halted
);

  localparam int unsigned INSTR_W = 3 * DATA_W;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_F0   = 3'd1;
  localparam logic [2:0] S_F1   = 3'd2;
  localparam logic [2:0] S_F2   = 3'd3;
  localparam logic [2:0] S_F3   = 3'd4;
  localparam logic [2:0] S_HOLD = 3'd5;

  logic [2:0]         state, state_d;
  logic [ADDR_W-1:0]  pc, pc_d;
  logic [DATA_W-1:0]  op_q, op_d;
  logic [DATA_W-1:0]  opnd1_q, opnd1_d;
  logic               rd_en_d;
  logic [ADDR_W-1:0]  addr_d;
  logic [INSTR_W-1:0] instr_d;
  logic [ADDR_W-1:0]  instr_pc_d;
  logic               valid_d;
  logic               halted_d;
  logic               accept;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next state, datapath updates and next values of the registered outputs
  always_comb begin
    state_d    = state;
    pc_d       = pc;
    op_d       = op_q;
    opnd1_d    = opnd1_q;
    rd_en_d    = 1'b0;
    addr_d     = mem_addr;
    instr_d    = instr;
    instr_pc_d = instr_pc;
    valid_d    = instr_valid;
    halted_d   = halted;
    accept     = instr_valid && instr_ready;

    if (redirect) begin
      pc_d     = redirect_addr;
      valid_d  = 1'b0;
      halted_d = 1'b0;
      state_d  = fetch_en ? S_F0 : S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (fetch_en && !halted) state_d = S_F0;
        S_F0:   state_d = S_F1;
        S_F1: begin
          op_d    = mem_data;
          state_d = S_F2;
        end
        S_F2: begin
          opnd1_d = mem_data;
          state_d = S_F3;
        end
        S_F3: begin
          instr_d    = {op_q, opnd1_q, mem_data};
          instr_pc_d = pc;
          valid_d    = 1'b1;
          state_d    = S_HOLD;
        end
        S_HOLD: begin
          if (accept) begin
            pc_d    = pc + ADDR_W'(3);
            valid_d = 1'b0;
            state_d = fetch_en ? S_F0 : S_IDLE;
`ifdef FETCH_HALT_DETECT_EN
            if (instr[INSTR_W-1 -: DATA_W] == {DATA_W{1'b1}}) begin
              halted_d = 1'b1;
              state_d  = S_IDLE;
            end
`else
            halted_d = 1'b0;
`endif
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Read strobe/address follow the state being entered so they line up with it
    case (state_d)
      S_F0: begin
        rd_en_d = 1'b1;
        addr_d  = pc_d;
      end
      S_F1: begin
        rd_en_d = 1'b1;
        addr_d  = pc_d + ADDR_W'(1);
      end
      S_F2: begin
        rd_en_d = 1'b1;
        addr_d  = pc_d + ADDR_W'(2);
      end
      default: rd_en_d = 1'b0;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc          <= RESET_PC;
      op_q        <= '0;
      opnd1_q     <= '0;
      mem_rd_en   <= 1'b0;
      mem_addr    <= '0;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      busy        <= 1'b0;
      halted      <= 1'b0;
    end else begin
      pc          <= pc_d;
      op_q        <= op_d;
      opnd1_q     <= opnd1_d;
      mem_rd_en   <= rd_en_d;
      mem_addr    <= addr_d;
      instr       <= instr_d;
      instr_pc    <= instr_pc_d;
      instr_valid <= valid_d;
      busy        <= (state_d != S_IDLE);
      halted      <= halted_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: RAM model, accept scoreboard, vector table plus corner-case sequences.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst;
  logic        fetch_en;
  logic        mem_rd_en;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_data;
  logic        redirect;
  logic [7:0]  redirect_addr;
  logic        instr_valid;
  logic        instr_ready;
  logic [23:0] instr;
  logic [7:0]  instr_pc;
  logic        busy;
  logic        halted;

  instr_fetch_unit dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_data(mem_data),
    .redirect(redirect), .redirect_addr(redirect_addr),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc), .busy(busy), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte RAM: data returned one cycle after the read strobe
  logic [7:0] ram [256];
  always @(posedge clk) if (mem_rd_en) mem_data <= ram[mem_addr];

  typedef struct packed {
    logic [23:0] instr;
    logic [7:0]  pc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int checks = 0;
  int errors = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, want);
    end
  endfunction

  // Accept monitor: a redirect in the same cycle drops the instruction instead
  always @(negedge clk) begin
    if (rst && instr_valid && instr_ready && !redirect) begin
      if (sb.size() == 0) begin
        chk("unexpected_accept", 32'(sb.size()), 32'd1);
      end else begin
        mon_e = sb.pop_front();
        chk("acc_instr", 32'(instr), 32'(mon_e.instr));
        chk("acc_pc", 32'(instr_pc), 32'(mon_e.pc));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    fetch_en = 1'b0;
    redirect = 1'b0;
    instr_ready = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  // Wait (bounded) for instr_valid while checking the three read addresses
  task automatic wait_valid(input logic [7:0] start, output int n);
    int k;
    bit ok;
    n = 0;
    k = 0;
    ok = 1'b1;
    while (!instr_valid && n < 20) begin
      if (mem_rd_en) begin
        if (mem_addr !== 8'(start + 8'(k))) ok = 1'b0;
        k++;
      end
      tick();
      n++;
    end
    chk("valid_seen", 32'(instr_valid), 32'd1);
    chk("rd_count", 32'(k), 32'd3);
    chk("rd_addr", 32'(ok), 32'd1);
  endtask

  typedef struct {
    logic [7:0]  pc;
    logic [7:0]  b0, b1, b2;
    int          stall;
    bit          drop_en;
    logic [23:0] exp_instr;
    logic [7:0]  exp_next;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int n;
    bit ok;
    vec_t v;

    vecs[0] = '{pc: 8'h00, b0: 8'h11, b1: 8'h22, b2: 8'h33, stall: 5, drop_en: 1'b0, exp_instr: 24'h112233, exp_next: 8'h03};
    vecs[1] = '{pc: 8'hFE, b0: 8'hAA, b1: 8'hBB, b2: 8'hCC, stall: 0, drop_en: 1'b1, exp_instr: 24'hAABBCC, exp_next: 8'h01};
    vecs[2] = '{pc: 8'h80, b0: 8'h5A, b1: 8'h00, b2: 8'hFF, stall: 2, drop_en: 1'b0, exp_instr: 24'h5A00FF, exp_next: 8'h83};
    vecs[3] = '{pc: 8'hFD, b0: 8'h12, b1: 8'h34, b2: 8'h56, stall: 1, drop_en: 1'b1, exp_instr: 24'h123456, exp_next: 8'h00};

    for (int i = 0; i < 256; i++) ram[i] = 8'(i * 7 + 3);
    redirect_addr = 8'h00;
    do_reset();

    // Reset state
    chk("rst_rd_en", 32'(mem_rd_en), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", 32'(instr), 32'd0);
    chk("rst_pc", 32'(instr_pc), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);

    // Basic fetch from IDLE with ready held high
    ram[0] = 8'h11; ram[1] = 8'h22; ram[2] = 8'h33;
    sb.push_back({24'h112233, 8'h00});
    fetch_en = 1'b1;
    instr_ready = 1'b1;
    wait_valid(8'h00, n);
    chk("lat_idle", 32'(n), 32'd5);
    tick();
    chk("next_valid_low", 32'(instr_valid), 32'd0);
    chk("next_rd_en", 32'(mem_rd_en), 32'd1);
    chk("next_pc", 32'(mem_addr), 32'h03);
    do_reset();

    // Vector table: redirect start, stall, accept, then next-pc probe
    for (int vi = 0; vi < 4; vi++) begin
      v = vecs[vi];
      ram[v.pc] = v.b0;
      ram[8'(v.pc + 8'd1)] = v.b1;
      ram[8'(v.pc + 8'd2)] = v.b2;
      instr_ready = 1'b0;
      fetch_en = 1'b1;
      redirect = 1'b1;
      redirect_addr = v.pc;
      sb.push_back({v.exp_instr, v.pc});
      tick();
      redirect = 1'b0;
      if (v.drop_en) fetch_en = 1'b0;
      wait_valid(v.pc, n);
      chk("lat_redir", 32'(n), 32'd4);
      ok = 1'b1;
      for (int s = 0; s < v.stall; s++) begin
        if (instr_valid !== 1'b1 || instr !== v.exp_instr || instr_pc !== v.pc || mem_rd_en !== 1'b0)
          ok = 1'b0;
        tick();
      end
      chk("stall_stable", 32'(ok), 32'd1);
      instr_ready = 1'b1;
      fetch_en = 1'b0;
      tick();
      instr_ready = 1'b0;
      chk("acc_valid_low", 32'(instr_valid), 32'd0);
      chk("acc_busy_low", 32'(busy), 32'd0);
      chk("acc_instr_kept", 32'(instr), 32'(v.exp_instr));
      chk("acc_rd_low", 32'(mem_rd_en), 32'd0);
      fetch_en = 1'b1;
      tick();
      chk("vec_next_pc", 32'(mem_addr), 32'(v.exp_next));
    end
    fetch_en = 1'b0;
    do_reset();

    // Redirect to 0xFE while in F2: partial fetch discarded, address wraps
    ram[0] = 8'h11; ram[1] = 8'h22; ram[2] = 8'h33;
    ram[8'hFE] = 8'hA1; ram[8'hFF] = 8'hB2;
    fetch_en = 1'b1;
    tick();
    tick();
    tick();
    redirect = 1'b1;
    redirect_addr = 8'hFE;
    sb.push_back({24'hA1B211, 8'hFE});
    tick();
    redirect = 1'b0;
    chk("f2redir_rd_en", 32'(mem_rd_en), 32'd1);
    wait_valid(8'hFE, n);
    chk("f2redir_lat", 32'(n), 32'd4);
    instr_ready = 1'b1;
    tick();
    chk("f2redir_next_pc", 32'(mem_addr), 32'h01);
    do_reset();

    // Redirect and ready together in HOLD: pending instruction dropped
    ram[8'h10] = 8'h44; ram[8'h11] = 8'h55; ram[8'h12] = 8'h66;
    fetch_en = 1'b1;
    wait_valid(8'h00, n);
    instr_ready = 1'b1;
    redirect = 1'b1;
    redirect_addr = 8'h10;
    sb.push_back({24'h445566, 8'h10});
    tick();
    redirect = 1'b0;
    fetch_en = 1'b0;
    chk("hold_redir_valid", 32'(instr_valid), 32'd0);
    chk("hold_redir_rd_en", 32'(mem_rd_en), 32'd1);
    chk("hold_redir_addr", 32'(mem_addr), 32'h10);
    wait_valid(8'h10, n);
    tick();
    chk("hold_redir_idle", 32'(busy), 32'd0);
    chk("hold_redir_sb", 32'(sb.size()), 32'd0);

    // Reset asserted during F1
    do_reset();
    ram[0] = 8'h77; ram[1] = 8'h88; ram[2] = 8'h99;
    fetch_en = 1'b1;
    instr_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("midrst_rd_en", 32'(mem_rd_en), 32'd0);
    chk("midrst_addr", 32'(mem_addr), 32'd0);
    chk("midrst_valid", 32'(instr_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_instr", 32'(instr), 32'd0);
    chk("midrst_pc", 32'(instr_pc), 32'd0);
    rst = 1'b1;
    sb.push_back({24'h778899, 8'h00});
    wait_valid(8'h00, n);
    chk("midrst_lat", 32'(n), 32'd5);
    fetch_en = 1'b0;
    tick();

    // All-ones opcode as the second instruction
    do_reset();
    ram[0] = 8'h01; ram[1] = 8'h02; ram[2] = 8'h03;
    ram[3] = 8'hFF; ram[4] = 8'h0A; ram[5] = 8'h0B;
    sb.push_back({24'h010203, 8'h00});
    sb.push_back({24'hFF0A0B, 8'h03});
    fetch_en = 1'b1;
    instr_ready = 1'b1;
    wait_valid(8'h00, n);
    tick();
    wait_valid(8'h03, n);
    tick();
`ifdef FETCH_HALT_DETECT_EN
    tick();
    tick();
    chk("halt_set", 32'(halted), 32'd1);
    chk("halt_busy", 32'(busy), 32'd0);
    chk("halt_rd_en", 32'(mem_rd_en), 32'd0);
    redirect = 1'b1;
    redirect_addr = 8'h00;
    sb.push_back({24'h010203, 8'h00});
    tick();
    redirect = 1'b0;
    chk("halt_cleared", 32'(halted), 32'd0);
    chk("halt_resume_busy", 32'(busy), 32'd1);
    wait_valid(8'h00, n);
    fetch_en = 1'b0;
    tick();
`else
    chk("nohalt_flag", 32'(halted), 32'd0);
    chk("nohalt_busy", 32'(busy), 32'd1);
    chk("nohalt_addr", 32'(mem_addr), 32'h06);
    instr_ready = 1'b0;
    fetch_en = 1'b0;
`endif
    do_reset();

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
